addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Parametrised, pipelined adder/subtractor; next generation of the ALU's 32-bit combinational add/sub unit.
- Splits the WIDTH-bit carry chain into SEGS registered segments.
- Adds a valid/ready handshake on both sides, carry-in/borrow modes, a pass-through tag, and a full flag set (carry, overflow, zero, negative).
- Sits between operand-issue logic and the ALU result mux. Sustains one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEGS.
- SEGS, 4, number of carry-chain segments = pipeline latency in cycles; 1..WIDTH.
- TAG_W, 4, width of the opaque tag carried alongside each operation; >= 1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 A+B, 01 A-B, 10 A+B+cin, 11 A-B-(~cin) (cin=1 means no borrow).
- cin  in  1  carry/no-borrow input, used only for op[1]=1.
- tag_in  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for subtraction: 1 = no borrow, i.e. A >= B unsigned).
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].
- tag_out  out  TAG_W  tag of the operation in sum.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits, out_valid, sum, cout, overflow, zero, neg and tag_out go to 0 immediately. Operations in flight are discarded. in_ready = 1 from the first edge after reset deasserts.
- Operand transform at acceptance:
  - B' = op[0] ? ~b : b.
  - Carry-in c0 = op[1] ? cin : op[0].
  - So A-B = A + ~B + 1, and op 11 with cin=0 gives A + ~B + 0.
- Segment k (0..SEGS-1) computes bits [k*W/S +: W/S] of A+B'+carry. Its carry-in is the carry-out of segment k-1, registered between stages.
- Unprocessed upper operand bits and the tag are registered alongside each stage. Segment 0 is computed combinationally from the accepted inputs and registered into stage 1.
- Latency: an operation accepted at edge N appears on out_valid/sum after edge N+SEGS-1, assuming no stall. For SEGS=1, the result registers update at the accepting edge.
- Flags:
  - Computed in the final segment.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero asserts when the whole sum is zero.
  - Flags are always registered together with sum, never ahead of it.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 1, every stage shifts forward one step and bubbles propagate as valid=0.
  - When advance = 0, all stages and the outputs hold. sum, flags and tag_out stay stable while out_valid && !out_ready.
  - An input is accepted on in_valid && in_ready. in_ready never depends combinationally on in_valid.
- Throughput: one op per cycle with out_ready held high. Back-to-back results carry no bubbles.
- Simultaneous consume + accept in the same cycle (out_valid && out_ready && in_valid) is legal: the pipeline shifts and the new op enters.
- Wrap-around: the sum is modulo 2^WIDTH. Carry and overflow are reported, never saturated.
- Output register contents with out_valid = 0 are don't-care for the bench, except immediately after reset (all 0).

Test Plan:
- WIDTH=32, SEGS=4, stream 0x7FFFFFFF+0x00000001 op00, tag 3 → 3 cycles after acceptance: sum 0x80000000, overflow 1, cout 0, neg 1, zero 0, tag_out 3.
- op01, a=5, b=5 → sum 0, zero 1, cout 1, overflow 0. Then op01, a=3, b=5 → sum 0xFFFFFFFE, cout 0, neg 1.
- Carry across segment boundary, op10, a=0x0000FFFF, b=0x00000000, cin=1 → sum 0x00010000. Then op11, a=0, b=0, cin=0 → sum 0xFFFFFFFF, cout 0.
- 8 back-to-back ops with out_ready=1 → 8 consecutive out_valid cycles, in order. Then drop out_ready for 5 cycles with in_valid high → in_ready=0, outputs frozen, no loss or duplication after release.
- Assert reset mid-stream with 3 ops in flight → all outputs 0 at once. After release, no stale result ever appears on out_valid.
- Sweep parameters (WIDTH=8, SEGS=1; WIDTH=64, SEGS=8) with 1000 random ops/op-codes against a reference model → all sum and flag values match, with latency equal to SEGS.

Source files
------------

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit adder/subtractor. The carry chain is cut into SEGS
// registered segments behind a valid/ready handshake, with carry/overflow/zero/neg flags.

module addsub_seg #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
endmodule

module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] tag_out
);
  localparam int SW = WIDTH / SEGS;
  localparam int NM = (SEGS > 1) ? SEGS - 1 : 1;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [SEGS:1]    vld_pipe;

  // Stage k holds operands, partial sum and the carry into segment k.
  logic [WIDTH-1:0] a_r   [1:NM];
  logic [WIDTH-1:0] b_r   [1:NM];
  logic [WIDTH-1:0] s_r   [1:NM];
  logic             c_r   [1:NM];
  logic [TAG_W-1:0] tag_r [1:NM];

  assign out_valid = vld_pipe[SEGS];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign bx        = op[0] ? ~b : b;
  assign c0        = op[1] ? cin : op[0];

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    logic             vi, ci, ck;
    logic [TAG_W-1:0] ti;
    logic [SW-1:0]    a_seg, b_seg, sk;
    logic [WIDTH-1:0] sn;

    if (k == 0) begin : g_src
      assign vi    = in_valid;
      assign ci    = c0;
      assign ti    = tag_in;
      assign a_seg = a[SW-1:0];
      assign b_seg = bx[SW-1:0];
      assign sn    = WIDTH'(sk);
    end else begin : g_src
      assign vi    = vld_pipe[k];
      assign ci    = c_r[k];
      assign ti    = tag_r[k];
      assign a_seg = a_r[k][k*SW +: SW];
      assign b_seg = b_r[k][k*SW +: SW];
      always_comb begin
        sn              = s_r[k];
        sn[k*SW +: SW]  = sk;
      end
    end

    addsub_seg #(.SW(SW)) u_seg (
      .a  (a_seg),
      .b  (b_seg),
      .ci (ci),
      .s  (sk),
      .co (ck)
    );

    if (k < SEGS - 1) begin : g_reg
      logic [WIDTH-1:0] af, bf;
      if (k == 0) begin : g_fw
        assign af = a;
        assign bf = bx;
      end else begin : g_fw
        assign af = a_r[k];
        assign bf = b_r[k];
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_pipe[k+1] <= 1'b0;
          a_r[k+1]      <= '0;
          b_r[k+1]      <= '0;
          s_r[k+1]      <= '0;
          c_r[k+1]      <= 1'b0;
          tag_r[k+1]    <= '0;
        end else if (adv) begin
          vld_pipe[k+1] <= vi;
          a_r[k+1]      <= af;
          b_r[k+1]      <= bf;
          s_r[k+1]      <= sn;
          c_r[k+1]      <= ck;
          tag_r[k+1]    <= ti;
        end
      end
    end else begin : g_out
      // Same-sign operands with a differently-signed result is exactly carry-in^carry-out at the MSB.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_pipe[SEGS] <= 1'b0;
          sum            <= '0;
          cout           <= 1'b0;
          overflow       <= 1'b0;
          zero           <= 1'b0;
          neg            <= 1'b0;
          tag_out        <= '0;
        end else if (adv) begin
          vld_pipe[SEGS] <= vi;
          sum            <= sn;
          cout           <= ck;
          overflow       <= (a_seg[SW-1] == b_seg[SW-1]) && (sk[SW-1] != a_seg[SW-1]);
          zero           <= ~|sn;
          neg            <= sn[WIDTH-1];
          tag_out        <= ti;
        end
      end
    end
  end
endmodule
